// File: rtl/pic_host_sequencer.sv
// Host-side bus sequencer for an 8259-style PIC: INIT/WRITE/READ command
// sequencing plus the two-pulse interrupt-acknowledge cycle.
`timescale 1ns/1ps
module pic_host_sequencer #(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP_W   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic       INT,
  output logic       WD,
  output logic       RD,
  output logic       A0,
  output logic       INTA,
  inout  wire  [7:0] data_bus,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       init_done
);

  typedef enum logic [2:0] {
    StIdle, StSetup, StStrobe, StHold, StAck1, StAckGap, StAck2
  } state_e;

  localparam logic [1:0] OpInit  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpRead  = 2'b10;
  localparam logic [1:0] OpNop   = 2'b11;

  localparam logic [3:0] PulseLoad = 4'(PULSE_W - 1);
  localparam logic [3:0] GapLoad   = 4'(GAP_W - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [1:0] step_q, step_d;
  logic [7:0] icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
  logic       a0_q, a0_d;
  logic [7:0] wdat_q, wdat_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] vector_q, vector_d;
  logic       vector_valid_q, vector_valid_d;
  logic       init_done_q, init_done_d;
  logic       ack_start;
  logic       nxt_valid;
  logic [1:0] nxt_step;
  logic       bus_phase;
  logic       wr_op;

  // Next-state, datapath updates and command handshake.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    step_d         = step_q;
    icw1_d         = icw1_q;
    icw2_d         = icw2_q;
    icw3_d         = icw3_q;
    icw4_d         = icw4_q;
    a0_d           = a0_q;
    wdat_d         = wdat_q;
    rd_data_d      = rd_data_q;
    rd_valid_d     = 1'b0;
    vector_d       = vector_q;
    vector_valid_d = 1'b0;
    init_done_d    = init_done_q;
    nxt_valid      = 1'b0;
    nxt_step       = 2'd0;

    // Acknowledge wins over any command presented in the same cycle.
    ack_start = (state_q == StIdle) && INT && init_done_q;
    cmd_ready = (state_q == StIdle) && !ack_start;

    unique case (state_q)
      StIdle: begin
        if (ack_start) begin
          state_d = StAck1;
          cnt_d   = PulseLoad;
        end else if (cmd_valid) begin
          op_d = cmd_op;
          unique case (cmd_op)
            OpInit: begin
              init_done_d = 1'b0;
              icw1_d      = icw1 | 8'h10;
              icw2_d      = icw2;
              icw3_d      = icw3;
              icw4_d      = icw4;
              step_d      = 2'd0;
              a0_d        = 1'b0;
              wdat_d      = icw1 | 8'h10;
              state_d     = StSetup;
            end
            OpWrite: begin
              a0_d    = cmd_a0;
              wdat_d  = cmd_data;
              state_d = StSetup;
            end
            OpRead: begin
              a0_d    = cmd_a0;
              state_d = StSetup;
            end
            default: ;
          endcase
        end
      end
      StSetup: begin
        state_d = StStrobe;
        cnt_d   = PulseLoad;
      end
      StStrobe: begin
        if (cnt_q == 4'd0) begin
          state_d = StHold;
          if (op_q == OpRead) begin
            rd_data_d  = data_bus;
            rd_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        state_d = StIdle;
        if (op_q == OpInit) begin
          // ICW3 only in cascade mode (SNGL=0), ICW4 only when IC4=1.
          unique case (step_q)
            2'd0: begin
              nxt_valid = 1'b1;
              nxt_step  = 2'd1;
            end
            2'd1: begin
              if (!icw1_q[1]) begin
                nxt_valid = 1'b1;
                nxt_step  = 2'd2;
              end else if (icw1_q[0]) begin
                nxt_valid = 1'b1;
                nxt_step  = 2'd3;
              end
            end
            2'd2: begin
              if (icw1_q[0]) begin
                nxt_valid = 1'b1;
                nxt_step  = 2'd3;
              end
            end
            default: ;
          endcase
          if (nxt_valid) begin
            step_d  = nxt_step;
            a0_d    = 1'b1;
            state_d = StSetup;
            wdat_d  = (nxt_step == 2'd1) ? icw2_q :
                      (nxt_step == 2'd2) ? icw3_q : icw4_q;
          end else begin
            init_done_d = 1'b1;
          end
        end
      end
      StAck1: begin
        if (cnt_q == 4'd0) begin
          state_d = StAckGap;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAckGap: begin
        if (cnt_q == 4'd0) begin
          state_d = StAck2;
          cnt_d   = PulseLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck2: begin
        if (cnt_q == 4'd0) begin
          vector_d       = data_bus;
          vector_valid_d = 1'b1;
          state_d        = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= 4'd0;
      op_q           <= OpNop;
      step_q         <= 2'd0;
      icw1_q         <= 8'h00;
      icw2_q         <= 8'h00;
      icw3_q         <= 8'h00;
      icw4_q         <= 8'h00;
      a0_q           <= 1'b0;
      wdat_q         <= 8'h00;
      rd_data_q      <= 8'h00;
      rd_valid_q     <= 1'b0;
      vector_q       <= 8'h00;
      vector_valid_q <= 1'b0;
      init_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      step_q         <= step_d;
      icw1_q         <= icw1_d;
      icw2_q         <= icw2_d;
      icw3_q         <= icw3_d;
      icw4_q         <= icw4_d;
      a0_q           <= a0_d;
      wdat_q         <= wdat_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
      init_done_q    <= init_done_d;
    end
  end

  // Bus strobes decoded from state so reset releases them asynchronously.
  always_comb begin
    bus_phase = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StHold);
    wr_op     = (op_q != OpRead);
    WD        = !((state_q == StStrobe) && wr_op);
    RD        = !(((state_q == StStrobe) && !wr_op) || (state_q == StAck2));
    INTA      = !((state_q == StAck1) || (state_q == StAck2));
    A0        = bus_phase ? a0_q : 1'b0;
  end

  assign data_bus     = (bus_phase && wr_op) ? wdat_q : 8'hzz;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign vector       = vector_q;
  assign vector_valid = vector_valid_q;
  assign init_done    = init_done_q;

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Randomized bench for pic_host_sequencer with a transaction-level PIC bus model.
`timescale 1ns/1ps
module tb_pic_host_sequencer;

  localparam int unsigned PW = 3;
  localparam int unsigned GW = 2;

  typedef struct packed {
    logic       a0;
    logic [7:0] d;
    logic [7:0] w;
  } bus_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b11;
  logic       cmd_a0 = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic [7:0] icw1 = 8'h00;
  logic [7:0] icw2 = 8'h00;
  logic [7:0] icw3 = 8'h00;
  logic [7:0] icw4 = 8'h00;
  logic       INT = 1'b0;
  logic       WD, RD, A0, INTA;
  wire  [7:0] data_bus;
  logic [7:0] rd_data, vector;
  logic       rd_valid, vector_valid, init_done;
  logic [7:0] pic_rd = 8'h00;
  logic [7:0] pic_vec = 8'h00;

  // PIC model: drives the bus whenever RD is low (read data or vector).
  assign data_bus = !RD ? (INTA ? pic_rd : pic_vec) : 8'hzz;

  pic_host_sequencer #(.PULSE_W(PW), .GAP_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a0(cmd_a0), .cmd_data(cmd_data),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .INT(INT),
    .WD(WD), .RD(RD), .A0(A0), .INTA(INTA), .data_bus(data_bus),
    .rd_data(rd_data), .rd_valid(rd_valid), .vector(vector),
    .vector_valid(vector_valid), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic exp_init_done = 1'b0;

  bus_t wr_q[$];
  bus_t rd_q[$];
  bus_t exp_wr[$];
  int   lo_q[$];
  int   gap_q[$];
  int   vv_cnt = 0;
  int   rv_cnt = 0;
  logic [7:0] vv_val = 8'h00;
  logic [7:0] rv_val = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: turns strobe activity into write/read/ack transactions.
  int   wd_run = 0, rd_run = 0, lo_run = 0, hi_run = 0, pulse_n = 0;
  logic wd_a0 = 1'b0, rd_a0 = 1'b0, prev_inta = 1'b1;
  logic [7:0] wd_dat = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wd_run = 0; rd_run = 0; lo_run = 0; hi_run = 0; pulse_n = 0; prev_inta = 1'b1;
      end else begin
        int lows;
        lows = int'(!WD) + int'(!RD) + int'(!INTA);
        check("strobe_excl", 32'((lows <= 1) || (lows == 2 && WD)), 32'd1);
        if (!WD) begin
          wd_run++; wd_a0 = A0; wd_dat = data_bus;
        end else if (wd_run > 0) begin
          wr_q.push_back('{a0: wd_a0, d: wd_dat, w: 8'(wd_run)});
          wd_run = 0;
        end
        if (!RD && INTA) begin
          rd_run++; rd_a0 = A0;
          check("rd_bus_undriven", 32'(data_bus), 32'(pic_rd));
        end else if (rd_run > 0) begin
          rd_q.push_back('{a0: rd_a0, d: 8'h00, w: 8'(rd_run)});
          rd_run = 0;
        end
        if (!INTA) begin
          if (prev_inta && (pulse_n % 2 == 1)) gap_q.push_back(hi_run);
          lo_run++; hi_run = 0;
        end else begin
          if (!prev_inta) begin
            lo_q.push_back(lo_run); lo_run = 0; pulse_n++;
          end
          hi_run++;
        end
        prev_inta = INTA;
        if (vector_valid) begin vv_cnt++; vv_val = vector; end
        if (rd_valid) begin rv_cnt++; rv_val = rd_data; end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    wr_q.delete(); rd_q.delete(); lo_q.delete(); gap_q.delete(); exp_wr.delete();
    vv_cnt = 0; rv_cnt = 0;
  endtask

  // Present a command and hold it until accepted; drops INT once INTA is seen.
  task automatic issue(input logic [1:0] op, input logic a0, input logic [7:0] d);
    logic acc;
    acc = 1'b0;
    cmd_op = op; cmd_a0 = a0; cmd_data = d; cmd_valid = 1'b1;
    #1;
    for (int n = 0; n < 200; n++) begin
      if (cmd_ready) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      step();
      if (!INTA) INT = 1'b0;
      #1;
    end
    check("cmd_accepted", 32'(acc), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_op();
    logic idle;
    idle = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (cmd_ready) begin
        idle = 1'b1;
        break;
      end
      step();
      if (!INTA) INT = 1'b0;
      #1;
    end
    check("back_to_idle", 32'(idle), 32'd1);
    check("init_done", 32'(init_done), 32'(exp_init_done));
    step();
    step();
  endtask

  task automatic check_writes();
    check("wr_count", 32'(wr_q.size()), 32'(exp_wr.size()));
    foreach (exp_wr[i]) begin
      if (i < wr_q.size()) begin
        check("wr_a0", 32'(wr_q[i].a0), 32'(exp_wr[i].a0));
        check("wr_data", 32'(wr_q[i].d), 32'(exp_wr[i].d));
        check("wr_width", 32'(wr_q[i].w), 32'(PW));
      end
    end
  endtask

  task automatic check_ack(input logic [7:0] vec);
    check("inta_pulses", 32'(lo_q.size()), 32'd2);
    foreach (lo_q[i]) check("inta_width", 32'(lo_q[i]), 32'(PW));
    check("inta_gaps", 32'(gap_q.size()), 32'd1);
    foreach (gap_q[i]) check("inta_gap", 32'(gap_q[i]), 32'(GW));
    check("vv_pulses", 32'(vv_cnt), 32'd1);
    check("vv_value", 32'(vv_val), 32'(vec));
    check("vector", 32'(vector), 32'(vec));
  endtask

  task automatic do_init(input logic [7:0] i1, input logic [7:0] i2,
                         input logic [7:0] i3, input logic [7:0] i4);
    clear_obs();
    exp_wr.push_back('{a0: 1'b0, d: i1 | 8'h10, w: 8'(PW)});
    exp_wr.push_back('{a0: 1'b1, d: i2, w: 8'(PW)});
    if (!i1[1]) exp_wr.push_back('{a0: 1'b1, d: i3, w: 8'(PW)});
    if (i1[0]) exp_wr.push_back('{a0: 1'b1, d: i4, w: 8'(PW)});
    icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4;
    issue(2'b00, 1'b0, 8'h00);
    check("init_cleared", 32'(init_done), 32'd0);
    // Words must have been captured at accept.
    icw1 = ~i1; icw2 = ~i2; icw3 = ~i3; icw4 = ~i4;
    exp_init_done = 1'b1;
    finish_op();
    check_writes();
    check("init_no_reads", 32'(rd_q.size()), 32'd0);
  endtask

  task automatic do_write(input logic a0, input logic [7:0] d);
    clear_obs();
    exp_wr.push_back('{a0: a0, d: d, w: 8'(PW)});
    issue(2'b01, a0, d);
    finish_op();
    check_writes();
    check("wr_no_reads", 32'(rd_q.size()), 32'd0);
  endtask

  task automatic do_read(input logic a0, input logic [7:0] b);
    clear_obs();
    pic_rd = b;
    issue(2'b10, a0, ~b);
    finish_op();
    check("rd_no_writes", 32'(wr_q.size()), 32'd0);
    check("rd_count", 32'(rd_q.size()), 32'd1);
    if (rd_q.size() > 0) begin
      check("rd_a0", 32'(rd_q[0].a0), 32'(a0));
      check("rd_width", 32'(rd_q[0].w), 32'(PW));
    end
    check("rv_pulses", 32'(rv_cnt), 32'd1);
    check("rv_value", 32'(rv_val), 32'(b));
    check("rd_data", 32'(rd_data), 32'(b));
  endtask

  task automatic do_nop();
    clear_obs();
    issue(2'b11, 1'b1, 8'hff);
    finish_op();
    check("nop_writes", 32'(wr_q.size()), 32'd0);
    check("nop_reads", 32'(rd_q.size()), 32'd0);
  endtask

  task automatic do_ack(input logic [7:0] vec);
    logic started;
    clear_obs();
    started = 1'b0;
    pic_vec = vec;
    INT = 1'b1;
    for (int n = 0; n < 50; n++) begin
      step();
      if (!INTA) begin
        started = 1'b1;
        break;
      end
    end
    check("ack_started", 32'(started), 32'd1);
    INT = 1'b0;
    finish_op();
    check_ack(vec);
    check("ack_no_writes", 32'(wr_q.size()), 32'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_WD", 32'(WD), 32'd1);
    check("rst_RD", 32'(RD), 32'd1);
    check("rst_INTA", 32'(INTA), 32'd1);
    check("rst_A0", 32'(A0), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_vector", 32'(vector), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_vv", 32'(vector_valid), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    step(); step(); step();
    rst_n = 1'b1;
    step();

    // Single-mode INIT with ICW4: no ICW3 write.
    do_init(8'h13, 8'h20, 8'h77, 8'h01);
    // Cascade INIT: all four words.
    do_init(8'h11, 8'h08, 8'h04, 8'h03);
    do_ack(8'h25);

    // INT and a WRITE arriving together: acknowledge runs first.
    clear_obs();
    exp_wr.push_back('{a0: 1'b1, d: 8'hc3, w: 8'(PW)});
    pic_vec = 8'h5a;
    INT = 1'b1;
    #1;
    check("ack_priority_ready", 32'(cmd_ready), 32'd0);
    issue(2'b01, 1'b1, 8'hc3);
    check("ack_before_write", 32'(vv_cnt), 32'd1);
    finish_op();
    check_writes();
    check_ack(8'h5a);

    do_read(1'b0, 8'h81);
    do_nop();

    // Reset during ACK1: INTA releases immediately, nothing captured later.
    clear_obs();
    pic_vec = 8'h99;
    INT = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 50; n++) begin
        step();
        if (!INTA) begin
          seen = 1'b1;
          break;
        end
      end
      check("rst_ack_started", 32'(seen), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_INTA", 32'(INTA), 32'd1);
    check("abort_RD", 32'(RD), 32'd1);
    check("abort_WD", 32'(WD), 32'd1);
    check("abort_init_done", 32'(init_done), 32'd0);
    check("abort_vector", 32'(vector), 32'd0);
    INT = 1'b0;
    exp_init_done = 1'b0;
    step(); step();
    rst_n = 1'b1;
    vv_cnt = 0;
    repeat (12) step();
    check("abort_no_vv", 32'(vv_cnt), 32'd0);
    check("abort_vector_after", 32'(vector), 32'd0);

    // Randomized mix against the transaction model.
    for (int it = 0; it < 40; it++) begin
      int unsigned r;
      r = $urandom_range(0, 4);
      unique case (r)
        0: do_init(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        1: do_write(1'($urandom), 8'($urandom));
        2: do_read(1'($urandom), 8'($urandom));
        3: do_nop();
        default: begin
          if (exp_init_done) do_ack(8'($urandom));
          else do_write(1'($urandom), 8'($urandom));
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
